// File: rtl/slt_serial.sv
// Bit-serial less-than comparator: one full-adder slice computes a - b LSB-first
// over N cycles, then the result is held behind a valid/ready output handshake.
module slt_serial #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         is_signed,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         lt,
  output logic         busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [N-1:0]  sh_a;
  logic [N-1:0]  sh_b;
  logic          msb_a;
  logic          msb_b;
  logic          mode_signed;
  logic          carry;
  logic [CW-1:0] cnt;
  logic          sum_bit;
  logic          carry_next;

  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // Signed compares with differing signs are decided by a's sign alone;
  // otherwise the MSB of a - b cannot overflow and gives the answer.
  function automatic logic lt_result(input logic s_mode, input logic sa,
                                     input logic sb, input logic sum_msb,
                                     input logic cout);
    if (!s_mode)
      return ~cout;
    else if (sa != sb)
      return sa;
    else
      return sum_msb;
  endfunction

  assign sum_bit    = sh_a[0] ^ sh_b[0] ^ carry;
  assign carry_next = maj(sh_a[0], sh_b[0], carry);

  // Control path: state, handshake flags, counter, carry and result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      lt        <= 1'b0;
      cnt       <= '0;
      carry     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            cnt      <= '0;
            carry    <= 1'b1;
          end
        end
        RUN: begin
          carry <= carry_next;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            lt        <= lt_result(mode_signed, msb_a, msb_b, sum_bit, carry_next);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Operand path: b is stored inverted so the carry-in of 1 completes a + ~b + 1.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      sh_a        <= a;
      sh_b        <= ~b;
      msb_a       <= a[N-1];
      msb_b       <= b[N-1];
      mode_signed <= is_signed;
    end else if (state == RUN) begin
      sh_a <= {1'b0, sh_a[N-1:1]};
      sh_b <= {1'b0, sh_b[N-1:1]};
    end
  end

endmodule

// File: tb/tb_slt_serial.sv
// Scoreboard bench for slt_serial: an N=32 instance for directed and random
// compares, and an N=4 instance swept over every operand pair in both modes.
module tb_slt_serial;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        iv32 = 1'b0, ir32, ov32, ordy32 = 1'b1, lt32, busy32, sg32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        iv4 = 1'b0, ir4, ov4, ordy4 = 1'b1, lt4, busy4, sg4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;

  slt_serial #(.N(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .is_signed(sg32), .out_valid(ov32), .out_ready(ordy32), .lt(lt32), .busy(busy32)
  );

  slt_serial #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .is_signed(sg4), .out_valid(ov4), .out_ready(ordy4), .lt(lt4), .busy(busy4)
  );

  typedef struct { logic lt; int acc; } exp_t;
  exp_t sb32[$];
  exp_t sb4[$];

  int n_checks = 0;
  int n_fail = 0;
  bit rnd_rdy = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic ref_lt32(input logic [31:0] x, input logic [31:0] y, input logic s);
    return s ? ($signed(x) < $signed(y)) : (x < y);
  endfunction

  function automatic logic ref_lt4(input logic [3:0] x, input logic [3:0] y, input logic s);
    return s ? ($signed(x) < $signed(y)) : (x < y);
  endfunction

  task automatic send32(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts);
    bit ok = 1'b0;
    @(posedge clk); #1;
    a32 = ta; b32 = tb_v; sg32 = ts; iv32 = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ir32) begin ok = 1'b1; break; end
    end
    if (!ok) check("accept32_timeout", 0, 1);
    else sb32.push_back('{ref_lt32(ta, tb_v, ts), cyc + 1});
    @(posedge clk); #1;
    iv32 = 1'b0; a32 = $urandom; b32 = $urandom; sg32 = $urandom_range(0, 1);
  endtask

  task automatic send4(input logic [3:0] ta, input logic [3:0] tb_v, input logic ts);
    bit ok = 1'b0;
    a4 = ta; b4 = tb_v; sg4 = ts; iv4 = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (ir4) begin ok = 1'b1; break; end
    end
    if (!ok) check("accept4_timeout", 0, 1);
    else sb4.push_back('{ref_lt4(ta, tb_v, ts), cyc + 1});
    @(posedge clk); #1;
    iv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
  endtask

  task automatic drain32;
    bit done = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (sb32.size() == 0) begin done = 1'b1; break; end
    end
    check("drain32", 64'(done), 1);
  endtask

  task automatic drain4;
    bit done = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (sb4.size() == 0) begin done = 1'b1; break; end
    end
    check("drain4", 64'(done), 1);
  endtask

  // Monitors: on the first cycle out_valid is seen, check result and latency;
  // pop when the handshake completes.
  initial begin
    bit seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) seen = 1'b0;
      else if (ov32) begin
        if (!seen) begin
          seen = 1'b1;
          if (sb32.size() == 0) check("unexpected_out32", 1, 0);
          else begin
            check("lt32", 64'(lt32), 64'(sb32[0].lt));
            check("latency32", 64'(cyc - sb32[0].acc), 32);
          end
        end
        if (ordy32) begin
          if (sb32.size() != 0) void'(sb32.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    bit seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) seen = 1'b0;
      else if (ov4) begin
        if (!seen) begin
          seen = 1'b1;
          if (sb4.size() == 0) check("unexpected_out4", 1, 0);
          else begin
            check("lt4", 64'(lt4), 64'(sb4[0].lt));
            check("latency4", 64'(cyc - sb4[0].acc), 4);
          end
        end
        if (ordy4) begin
          if (sb4.size() != 0) void'(sb4.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_rdy) ordy32 = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    bit got;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready32", 64'(ir32), 1);
    check("rst_out_valid32", 64'(ov32), 0);
    check("rst_lt32", 64'(lt32), 0);
    check("rst_busy32", 64'(busy32), 0);
    check("rst_in_ready4", 64'(ir4), 1);
    check("rst_out_valid4", 64'(ov4), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    send32(32'hFFFF_FFFB, 32'd3, 1'b1);
    send32(32'hFFFF_FFFB, 32'd3, 1'b0);
    send32(32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
    send32(32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
    send32(32'h1234_5678, 32'h1234_5678, 1'b1);
    send32(32'h0000_0000, 32'h0000_0001, 1'b0);
    drain32();
    @(negedge clk);
    check("lt_held_after_done", 64'(lt32), 1);

    // Reset during RUN: the previous result (1) must be cleared.
    send32(32'h0000_0055, 32'h0000_0066, 1'b0);
    repeat (14) @(posedge clk);
    #1 rst = 1'b1;
    sb32.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 64'(ov32), 0);
    check("midrst_in_ready", 64'(ir32), 1);
    check("midrst_lt", 64'(lt32), 0);
    check("midrst_busy", 64'(busy32), 0);
    send32(32'd1, 32'd2, 1'b1);
    drain32();

    // Backpressure: result must hold while out_ready is low.
    @(posedge clk); #1;
    ordy32 = 1'b0;
    send32(32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ov32) begin got = 1'b1; break; end
    end
    check("bp_out_valid_seen", 64'(got), 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_out_valid_hold", 64'(ov32), 1);
      check("bp_lt_hold", 64'(lt32), 64'(ref_lt32(32'h8000_0000, 32'h7FFF_FFFF, 1'b1)));
      check("bp_in_ready_low", 64'(ir32), 0);
    end
    @(posedge clk); #1;
    ordy32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_in_ready", 64'(ir32), 1);
    check("bp_release_out_valid", 64'(ov32), 0);

    // Random compares with random consumer backpressure.
    rnd_rdy = 1'b1;
    for (int t = 0; t < 50; t++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = {ra[31:8], 8'($urandom)};
        default: rb = $urandom;
      endcase
      send32(ra, rb, 1'($urandom_range(0, 1)));
    end
    rnd_rdy = 1'b0;
    @(posedge clk); #2;
    ordy32 = 1'b1;
    drain32();

    // Exhaustive N=4 sweep, both modes.
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 16; i++)
        for (int j = 0; j < 16; j++)
          send4(4'(i), 4'(j), 1'(s));
    drain4();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
